// File: rtl/hx711_sample_filter.sv
// Sequencer and moving-average filter for the HX711 serial driver.
// Keeps the driver converting, averages 2^LOG2_N samples, applies tare and flags mass steps.
module hx711_sample_filter #(
   parameter int LOG2_N      = 3,
   parameter int THRESH      = 100,
   parameter int TIMEOUT_CYC = 20000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               flush,
   input  logic               tare_req,
   input  logic               hx_ready,
   input  logic               hx_done_tick,
   input  logic [23:0]        hx_dout,
   output logic               hx_start,
   output logic signed [23:0] avg_raw,
   output logic signed [24:0] net_weight,
   output logic               out_valid,
   output logic               change_tick,
   output logic               busy,
   output logic               timeout_err
);
   localparam int N  = 1 << LOG2_N;
   localparam int SW = 24 + LOG2_N;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [LOG2_N:0]      FULL  = (LOG2_N + 1)'(N);
   localparam logic [TW-1:0]        TLAST = TW'(TIMEOUT_CYC - 1);
   localparam logic signed [25:0]   TH    = 26'(THRESH);

   localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, WAIT = 3'd2, ACC = 3'd3, OUT = 3'd4;

   logic [2:0]              state;
   logic [TW-1:0]           timer;
   logic signed [23:0]      sample;
   logic signed [23:0]      win [N];
   logic signed [SW-1:0]    sum;
   logic [LOG2_N-1:0]       wr_ptr;
   logic [LOG2_N:0]         fill;
   logic signed [23:0]      tare_reg;
   logic signed [24:0]      prev_net;
   logic                    primed;
   logic                    tare_pending;

   logic signed [SW-1:0]    sum_nxt;
   logic [LOG2_N:0]         fill_nxt;
   logic signed [23:0]      avg_nxt;
   logic signed [24:0]      net_nxt;
   logic signed [25:0]      diff;
   logic                    over;

   // Outputs are computed from the post-ACC window so they appear during OUT.
   always_comb begin
      sum_nxt  = sum + {{LOG2_N{sample[23]}}, sample} - {{LOG2_N{win[wr_ptr][23]}}, win[wr_ptr]};
      fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
      avg_nxt  = 24'(sum_nxt >>> LOG2_N);
      net_nxt  = {avg_nxt[23], avg_nxt} - {tare_reg[23], tare_reg};
      diff     = {net_nxt[24], net_nxt} - {prev_net[24], prev_net};
      over     = (diff > TH) || (diff < -TH);
   end

   assign hx_start = (state == REQ);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= '0;
         sample      <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               timer <= '0;
               if (en && hx_ready) state <= REQ;
            end
            REQ: begin
               if (timer == TLAST) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
                  if (!hx_ready) state <= WAIT;
               end
            end
            WAIT: begin
               // en is deliberately ignored here: a started conversion always completes
               if (timer == TLAST) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
                  if (hx_done_tick) begin
                     sample <= hx_dout;
                     state  <= ACC;
                  end
               end
            end
            ACC:     state <= OUT;
            OUT:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) win[i] <= '0;
         sum    <= '0;
         wr_ptr <= '0;
         fill   <= '0;
      end else if (flush) begin
         for (int i = 0; i < N; i++) win[i] <= '0;
         sum    <= '0;
         wr_ptr <= '0;
         fill   <= '0;
      end else if (state == ACC) begin
         win[wr_ptr] <= sample;
         sum         <= sum_nxt;
         wr_ptr      <= wr_ptr + 1'b1;
         fill        <= fill_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         avg_raw      <= '0;
         net_weight   <= '0;
         out_valid    <= 1'b0;
         change_tick  <= 1'b0;
         tare_reg     <= '0;
         prev_net     <= '0;
         primed       <= 1'b0;
         tare_pending <= 1'b0;
      end else begin
         out_valid   <= 1'b0;
         change_tick <= 1'b0;
         if (tare_req) tare_pending <= 1'b1;
         if (flush) begin
            primed <= 1'b0;
         end else if (state == ACC && fill_nxt == FULL) begin
            out_valid <= 1'b1;
            avg_raw   <= avg_nxt;
            primed    <= 1'b1;
            if (tare_pending) begin
               tare_reg     <= avg_nxt;
               net_weight   <= '0;
               prev_net     <= '0;
               tare_pending <= 1'b0;
            end else begin
               net_weight  <= net_nxt;
               prev_net    <= net_nxt;
               change_tick <= primed & over;
            end
         end
      end
   end
endmodule

// File: tb/tb_hx711_sample_filter.sv
// Bench for hx711_sample_filter: vector table driven through a driver model, scoreboard on out_valid.
module tb_hx711_sample_filter;
   localparam int TO = 1000;

   logic clk = 0, reset = 1, en = 0, flush = 0, tare_req = 0;
   logic hx_ready = 1, hx_done_tick = 0;
   logic [23:0] hx_dout = '0;
   logic hx_start, out_valid, change_tick, busy, timeout_err;
   logic signed [23:0] avg_raw;
   logic signed [24:0] net_weight;

   int cyc = 0;
   int n_cmp = 0, n_bad = 0;

   hx711_sample_filter #(.LOG2_N(3), .THRESH(100), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .tare_req(tare_req),
      .hx_ready(hx_ready), .hx_done_tick(hx_done_tick), .hx_dout(hx_dout),
      .hx_start(hx_start), .avg_raw(avg_raw), .net_weight(net_weight),
      .out_valid(out_valid), .change_tick(change_tick), .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [23:0] avg; logic [24:0] net; logic chg; } exp_t;
   typedef struct {
      logic [23:0] dout; bit tare; bit flush_before;
      bit v; logic [23:0] avg; logic [24:0] net; bit chg;
   } vec_t;

   exp_t sbq[$];
   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(logic [23:0] d, bit t, bit fb, bit v, int avg, int net, bit c);
      vec_t r;
      r.dout = d; r.tare = t; r.flush_before = fb;
      r.v = v; r.avg = 24'(avg); r.net = 25'(net); r.chg = c;
      return r;
   endfunction

   // Scoreboard: every out_valid must match the oldest expectation, at its exact cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            chk("missing_out_valid", 32'(sbq[0].cyc), 32'(cyc));
            void'(sbq.pop_front());
         end
         if (out_valid) begin
            if (sbq.size() == 0) begin
               chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("latency_cyc", 32'(cyc), 32'(e.cyc));
               chk("avg_raw", {8'h0, avg_raw}, {8'h0, e.avg});
               chk("net_weight", {7'h0, net_weight}, {7'h0, e.net});
               chk("change_tick", 32'(change_tick), 32'(e.chg));
            end
         end else if (change_tick) begin
            chk("change_without_valid", 32'(change_tick), 32'd0);
         end
      end
   end

   task automatic wait_start();
      int n = 0;
      while (!hx_start && n < 50) begin @(negedge clk); n++; end
      if (!hx_start) chk("hx_start_timeout", 32'(hx_start), 32'd1);
   endtask

   task automatic drive(input vec_t v, input bit flush_acc);
      if (v.flush_before) begin flush = 1; @(negedge clk); flush = 0; end
      wait_start();
      hx_ready = 0; tare_req = v.tare;
      @(negedge clk); tare_req = 0;
      @(negedge clk);
      hx_done_tick = 1; hx_dout = v.dout;
      if (v.v) sbq.push_back('{cyc + 2, v.avg, v.net, v.chg});
      @(negedge clk); hx_done_tick = 0; hx_ready = 1; flush = flush_acc;
      @(negedge clk); flush = 0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_avg"}, {8'h0, avg_raw}, 32'd0);
      chk({tag, "_net"}, {7'h0, net_weight}, 32'd0);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_chg"}, 32'(change_tick), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_start"}, 32'(hx_start), 32'd0);
      chk({tag, "_tmo"}, 32'(timeout_err), 32'd0);
   endtask

   initial begin
      // steady 256: only the 8th sample fills the window
      for (int i = 0; i < 8; i++) vt.push_back(mk(24'h000100, 0, 0, i == 7, 256, 256, 0));
      // negative samples displace the 256s; avg drops 64 per sample
      for (int k = 1; k <= 8; k++) vt.push_back(mk(24'hFFFF00, 0, 0, 1, 256 - 64 * k, 256 - 64 * k, 0));
      // tare at 1000 on a freshly flushed window
      for (int i = 0; i < 8; i++) vt.push_back(mk(24'd1000, i == 7, i == 0, i == 7, 1000, 0, 0));
      // step to 1200: net grows by 25 per sample
      for (int k = 1; k <= 8; k++) vt.push_back(mk(24'd1200, 0, 0, 1, 1000 + 25 * k, 25 * k, 0));
      // threshold boundary: diff 100 (no tick), 101 (tick), large negative step
      vt.push_back(mk(24'd2000, 0, 0, 1, 1300, 300, 0));
      vt.push_back(mk(24'd2008, 0, 0, 1, 1401, 401, 1));
      vt.push_back(mk(24'(-20000), 0, 0, 1, -1249, -2249, 1));
      // ramp 0..19 after flush: pointer wraps twice, avg = n-4
      for (int n = 0; n < 20; n++) vt.push_back(mk(24'(n), 0, n == 0, n >= 7, n - 4, n - 1004, 0));

      repeat (2) @(negedge clk);
      check_zero("reset");
      reset = 0; en = 1;
      @(negedge clk);

      foreach (vt[i]) drive(vt[i], 0);

      // flush coincident with ACC discards the sample and empties the window
      drive(mk(24'd5000, 0, 0, 0, 0, 0, 0), 1);
      for (int i = 0; i < 8; i++) drive(mk(24'd500, 0, 0, i == 7, 500, -500, 0), 0);

      // reset during WAIT: late driver tick is ignored, tare is cleared
      wait_start();
      hx_ready = 0;
      repeat (2) @(negedge clk);
      reset = 1;
      #1 check_zero("wait_reset");
      @(negedge clk); reset = 0;
      hx_done_tick = 1; hx_dout = 24'd7777;
      @(negedge clk); hx_done_tick = 0; hx_ready = 1;
      for (int i = 0; i < 8; i++) drive(mk(24'd100, 0, 0, i == 7, 100, 100, 0), 0);
      repeat (4) @(negedge clk);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

      // timeout: driver never acknowledges
      en = 0; reset = 1;
      @(negedge clk); reset = 0;
      @(negedge clk); en = 1;
      begin
         int n = 0, e;
         while (!busy && n < 5) begin @(negedge clk); n++; end
         chk("tmo_enter_req", 32'(busy), 32'd1);
         e = cyc;
         while (cyc < e + TO - 1) @(negedge clk);
         chk("tmo_before_err", 32'(timeout_err), 32'd0);
         chk("tmo_before_busy", 32'(busy), 32'd1);
         @(negedge clk);
         chk("tmo_err", 32'(timeout_err), 32'd1);
         chk("tmo_idle", 32'(busy), 32'd0);
         @(negedge clk);
         chk("tmo_retry", 32'(busy), 32'd1);
         chk("tmo_sticky", 32'(timeout_err), 32'd1);
      end
      chk("no_output_on_timeout", 32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
